alu_op_sequencer: RTL and testbench

Multi-cycle control stage directly upstream of the ALU. It accepts one register-to-register instruction per handshake, reads both source operands from the register file over a single read port, latches them, drives the ALU's `opcode`/`exec`/operand inputs for one cycle, and captures the result. It then issues a one-cycle writeback to the destination register and counts completed operations.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_sequencer_if.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode constants and sequencer state encoding shared with the ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MAX = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
// ============================================================================
// alu_op_sequencer_if : request, register-file, ALU and writeback bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_op_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter int CW    = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [AW-1:0]    req_ra;
  logic [AW-1:0]    req_rb;
  logic [AW-1:0]    req_rc;
  logic [AW-1:0]    rf_raddr;
  logic [WIDTH-1:0] rf_rdata;
  logic [3:0]       alu_opcode;
  logic             alu_exec;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             err;
  logic [CW-1:0]    op_count;

  // master: the surrounding datapath (requester, register file, ALU)
  modport master (
    output req_valid, req_opcode, req_ra, req_rb, req_rc, rf_rdata, alu_result,
    input  req_ready, rf_raddr, alu_opcode, alu_exec, alu_a, alu_b,
           wb_valid, wb_addr, wb_data, err, op_count
  );

  modport slave (
    input  req_valid, req_opcode, req_ra, req_rb, req_rc, rf_rdata, alu_result,
    output req_ready, rf_raddr, alu_opcode, alu_exec, alu_a, alu_b,
           wb_valid, wb_addr, wb_data, err, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : reads two operands, fires the ALU, writes back the result
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter int CW    = 16
) (
  input  wire logic          clk,
  input  wire logic          clr,
  alu_op_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    ra_q, ra_d;
  logic [AW-1:0]    rb_q, rb_d;
  logic [AW-1:0]    rc_q, rc_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    rc_d          = rc_q;
    wb_addr_d     = wb_addr_q;
    a_d           = a_q;
    b_d           = b_q;
    z_d           = z_q;
    cnt_d         = cnt_q;
    bus.req_ready = 1'b0;
    bus.rf_raddr  = '0;
    bus.alu_exec  = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.err       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_opcode;
          ra_d    = bus.req_ra;
          rb_d    = bus.req_rb;
          rc_d    = bus.req_rc;
          state_d = op_legal(bus.req_opcode) ? ST_RDA : ST_ERR;
        end
      end
      ST_RDA: begin
        bus.rf_raddr = ra_q;
        a_d          = bus.rf_rdata;
        state_d      = ST_RDB;
      end
      ST_RDB: begin
        bus.rf_raddr = rb_q;
        b_d          = bus.rf_rdata;
        state_d      = ST_EXEC;
      end
      ST_EXEC: begin
        // result and destination move together so the writeback pair only
        // changes on the edge where wb_valid rises
        bus.alu_exec = 1'b1;
        z_d          = bus.alu_result;
        wb_addr_d    = rc_q;
        state_d      = ST_WB;
      end
      ST_WB: begin
        bus.wb_valid = 1'b1;
        cnt_d        = cnt_q + CW'(1);
        state_d      = ST_IDLE;
      end
      ST_ERR: begin
        bus.err = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      wb_addr_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      wb_addr_q <= wb_addr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.alu_opcode = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = z_q;
  assign bus.op_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : random and directed scoreboard bench for the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int CW    = 4;   // narrow counter so wrap-around is reached quickly

  logic clk = 1'b0;
  logic clr = 1'b1;

  alu_op_sequencer_if #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_err;
    logic [3:0]       op;
    logic [AW-1:0]    ra, rb, rc;
    logic [WIDTH-1:0] a, b, z;
    int               cnt;
    int               e;
  } item_t;

  logic [WIDTH-1:0] rf [1<<AW];
  item_t            q [$];
  int               n_cmp = 0, n_bad = 0;
  int               ecount = 0, busy_until = -1, model_cnt = 0, acc_cnt = 0;
  int               acc_e_last = 0, acc_e_prev = 0, err_seen = 0;
  logic [AW-1:0]    last_addr = '0, dut_wb_addr = '0;
  logic [WIDTH-1:0] last_data = '0, dut_wb_data = '0;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a, b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb bus.rf_rdata   = rf[bus.rf_raddr];
  always_comb bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_cnt < target && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (acc_cnt < target) chk("accept_timeout", 32'(acc_cnt), 32'(target));
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || ecount <= busy_until) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("idle_timeout", 32'(q.size()), 32'd0);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] a, b, c);
    int start = acc_cnt;
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_ra     = a;
    bus.req_rb     = b;
    bus.req_rc     = c;
    wait_acc(start + 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic randomize_fields(input bit legal_only);
    bus.req_opcode = legal_only ? 4'($urandom_range(0, 4))
                   : (($urandom % 6 == 0) ? 4'($urandom_range(5, 15))
                                          : 4'($urandom_range(0, 4)));
    bus.req_ra = AW'($urandom);
    bus.req_rb = AW'($urandom);
    bus.req_rc = AW'($urandom);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_opcode = '0;
    bus.req_ra     = '0;
    bus.req_rb     = '0;
    bus.req_rc     = '0;
    for (int i = 0; i < (1 << AW); i++) rf[i] = $urandom;

    fork
      // acceptance: the reference model decides readiness and pushes the expectation
      forever begin
        @(posedge clk);
        if (clr) begin
          q.delete();
          busy_until = -1;
          model_cnt  = 0;
          last_addr  = '0;
          last_data  = '0;
        end else if (bus.req_valid && ecount > busy_until) begin
          item_t it;
          it.is_err = (bus.req_opcode > 4'd4);
          it.op     = bus.req_opcode;
          it.ra     = bus.req_ra;
          it.rb     = bus.req_rb;
          it.rc     = bus.req_rc;
          it.a      = rf[bus.req_ra];
          it.b      = rf[bus.req_rb];
          it.z      = alu_ref(it.op, it.a, it.b);
          it.cnt    = model_cnt;
          it.e      = ecount;
          q.push_back(it);
          busy_until = it.is_err ? ecount + 1 : ecount + 4;
          if (!it.is_err) model_cnt = (model_cnt + 1) % (1 << CW);
          acc_e_prev = acc_e_last;
          acc_e_last = ecount;
          acc_cnt++;
        end
        ecount++;
      end

      // monitor: compares DUT outputs against the front of the scoreboard
      forever begin
        @(negedge clk);
        if (!clr) begin
          logic [AW-1:0] raddr_e;
          bit exec_e, wb_e, err_e;
          int cnt_e, ph;
          raddr_e = '0; exec_e = 0; wb_e = 0; err_e = 0; cnt_e = model_cnt; ph = 0;
          if (bus.wb_valid) begin
            dut_wb_addr = bus.wb_addr;
            dut_wb_data = bus.wb_data;
          end
          if (bus.err) err_seen++;
          chk("req_ready", 32'(bus.req_ready), 32'(ecount > busy_until));
          if (q.size() != 0) begin
            ph    = ecount - q[0].e;
            cnt_e = q[0].cnt;
            if (q[0].is_err) err_e = (ph == 1);
            else begin
              raddr_e = (ph == 1) ? q[0].ra : (ph == 2) ? q[0].rb : '0;
              exec_e  = (ph == 3);
              wb_e    = (ph == 4);
            end
          end
          chk("rf_raddr", 32'(bus.rf_raddr), 32'(raddr_e));
          chk("alu_exec", 32'(bus.alu_exec), 32'(exec_e));
          chk("wb_valid", 32'(bus.wb_valid), 32'(wb_e));
          chk("err",      32'(bus.err),      32'(err_e));
          chk("op_count", 32'(bus.op_count), 32'(cnt_e));
          if (exec_e) begin
            chk("alu_a",      bus.alu_a,            q[0].a);
            chk("alu_b",      bus.alu_b,            q[0].b);
            chk("alu_opcode", 32'(bus.alu_opcode),  32'(q[0].op));
          end
          if (wb_e) begin
            last_addr = q[0].rc;
            last_data = q[0].z;
            rf[q[0].rc] = q[0].z;
          end
          chk("wb_addr", 32'(bus.wb_addr), 32'(last_addr));
          chk("wb_data", bus.wb_data, last_data);
          if (wb_e || err_e) void'(q.pop_front());
        end
      end

      begin
        int e0, start, errs0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready",    32'(bus.req_ready), 32'd1);
        chk("rst_wb_valid", 32'(bus.wb_valid),  32'd0);
        chk("rst_op_count", 32'(bus.op_count),  32'd0);
        chk("rst_alu_a",    bus.alu_a,          32'd0);
        clr = 1'b0;
        @(negedge clk); #1;

        rf[1] = 32'd5; rf[2] = 32'd7;
        issue(OP_ADD, 4'd1, 4'd2, 4'd3);
        wait_idle();
        chk("add_wb_data", dut_wb_data, 32'd12);
        chk("add_wb_addr", 32'(dut_wb_addr), 32'd3);
        chk("add_count",   32'(bus.op_count), 32'd1);

        rf[1] = 32'd0; rf[2] = 32'd1;
        issue(OP_SUB, 4'd1, 4'd2, 4'd4);
        wait_idle();
        chk("sub_wrap", dut_wb_data, 32'hFFFF_FFFF);

        rf[1] = 32'hFFFF_0000; rf[2] = 32'h0F0F_0F0F;
        issue(OP_XOR, 4'd1, 4'd2, 4'd5);
        wait_idle();
        chk("xor_data", dut_wb_data, 32'hF0F0_0F0F);

        rf[6] = 32'd3;
        issue(OP_ADD, 4'd6, 4'd6, 4'd6);
        wait_idle();
        chk("same_reg", dut_wb_data, 32'd6);

        errs0 = err_seen;
        issue(4'd9, 4'd1, 4'd2, 4'd3);
        wait_idle();
        chk("illegal_err_pulses", 32'(err_seen - errs0), 32'd1);
        chk("illegal_count",      32'(bus.op_count),     32'd4);

        // two ops with req_valid held; fields scrambled while busy
        start = acc_cnt;
        bus.req_valid = 1'b1;
        bus.req_opcode = OP_OR; bus.req_ra = 4'd1; bus.req_rb = 4'd2; bus.req_rc = 4'd7;
        wait_acc(start + 1);
        for (int t = 0; t < 40 && acc_cnt < start + 2; t++) begin
          randomize_fields(1'b1);
          @(negedge clk); #1;
        end
        chk("b2b_gap", 32'(acc_e_last - acc_e_prev), 32'd5);
        bus.req_opcode = 4'd12;
        wait_acc(start + 3);
        bus.req_opcode = OP_AND;
        wait_acc(start + 4);
        bus.req_valid = 1'b0;
        chk("err_gap", 32'(acc_e_last - acc_e_prev), 32'd2);
        wait_idle();

        // asynchronous reset landing mid-cycle during EXEC
        issue(OP_ADD, 4'd1, 4'd2, 4'd8);
        e0 = acc_e_last;
        while (ecount < e0 + 3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("abort_ready",    32'(bus.req_ready), 32'd1);
        chk("abort_exec",     32'(bus.alu_exec),  32'd0);
        chk("abort_count",    32'(bus.op_count),  32'd0);
        chk("abort_alu_a",    bus.alu_a,          32'd0);
        chk("abort_wb_data",  bus.wb_data,        32'd0);
        @(negedge clk); @(negedge clk); #1;
        clr = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        rf[9] = 32'd100; rf[10] = 32'd23;
        issue(OP_SUB, 4'd9, 4'd10, 4'd11);
        wait_idle();
        chk("post_abort_data",  dut_wb_data,       32'd77);
        chk("post_abort_count", 32'(bus.op_count), 32'd1);

        for (int c = 0; c < 2500; c++) begin
          bus.req_valid = ($urandom % 3 == 0);
          randomize_fields(1'b0);
          @(negedge clk); #1;
        end
        bus.req_valid = 1'b0;
        wait_idle();
        chk("final_count", 32'(bus.op_count), 32'(model_cnt));
      end
    join_any

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
